arduino_cmd_rx: RTL

//  UART receiver (8N1) for the Arduino command link. Produces the 8-bit arduino_command

---
 rtl/car_ctrl_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/arduino_cmd_rx.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/car_ctrl_pkg.sv
// Shared definitions for the car control path: the fallback command, the
// receiver state encoding and the drive command bytes understood by control_base.
package car_ctrl_pkg;

    // Byte that means "stop the car"; used on reset and when the link goes silent
    localparam logic [7:0] STOP_CMD = 8'h00;

    // ASCII drive commands sent by the Arduino
    localparam logic [7:0] CMD_W = 8'h77;
    localparam logic [7:0] CMD_S = 8'h73;
    localparam logic [7:0] CMD_A = 8'h61;
    localparam logic [7:0] CMD_D = 8'h64;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input. The reset value is
// a parameter so an idle-high serial line can come out of reset looking idle.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Retime the raw input through two flops to settle metastability
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/arduino_cmd_rx.sv
// 8N1 UART receiver for the Arduino command link, with a link watchdog that
// forces the command byte back to the stop command when frames stop arriving.
module arduino_cmd_rx #(
    parameter int         CLK_HZ         = 50_000_000,
    parameter int         BAUD           = 9600,
    parameter int         TIMEOUT_CYCLES = 25_000_000,
    parameter logic [7:0] STOP_CMD       = car_ctrl_pkg::STOP_CMD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] arduino_command,
    output logic       cmd_valid,
    output logic       frame_err,
    output logic       link_timeout
);

    import car_ctrl_pkg::*;

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int WD_W         = $clog2(TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);

    logic             rxSync;

    rx_state_t        state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic [7:0]       shift_q,  shift_d;

    logic             frameDone;
    logic             frameBad;

    logic [7:0]       cmd_q;
    logic             cmdValid_q;
    logic             frameErr_q;
    logic             timeout_q;
    logic [WD_W-1:0]  wd_q;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (uart_rx),
        .q_o   (rxSync)
    );

    // Receiver state, bit timer, bit index and shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bitIdx_q <= '0;
            shift_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitIdx_q <= bitIdx_d;
            shift_q  <= shift_d;
        end
    end

    // Frame sequencing: half-bit wait to centre on the start bit, then one bit period per sample
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bitIdx_d  = bitIdx_q;
        shift_d   = shift_q;
        frameDone = 1'b0;
        frameBad  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rxSync) begin
                    state_d = START;
                    cnt_d   = HALF_LOAD;
                end
            end

            START: begin
                if (cnt_q == '0) begin
                    if (!rxSync) begin
                        state_d  = DATA;
                        cnt_d    = FULL_LOAD;
                        bitIdx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rxSync, shift_q[7:1]};
                    cnt_d   = FULL_LOAD;
                    if (bitIdx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            STOP: begin
                if (cnt_q == '0) begin
                    if (rxSync) begin
                        frameDone = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        frameBad = 1'b1;
                        state_d  = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            BREAK: begin
                if (rxSync) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status strobes are registered so they rise one clock after the stop-bit sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmdValid_q <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            cmdValid_q <= frameDone;
            frameErr_q <= frameBad;
        end
    end

    // Command register and watchdog; a completing frame takes priority over a timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q     <= STOP_CMD;
            timeout_q <= 1'b0;
            wd_q      <= '0;
        end else if (frameDone) begin
            cmd_q     <= shift_q;
            timeout_q <= 1'b0;
            wd_q      <= '0;
        end else if (wd_q == WD_LAST) begin
            cmd_q     <= STOP_CMD;
            timeout_q <= 1'b1;
        end else begin
            wd_q <= wd_q + 1'b1;
        end
    end

    assign arduino_command = cmd_q;
    assign cmd_valid       = cmdValid_q;
    assign frame_err       = frameErr_q;
    assign link_timeout    = timeout_q;

endmodule
